exe_stage_multicycle: RTL and testbench
=======================================

// Module: exe_stage_multicycle
// PURPOSE
//  Execute stage. Consumes the ID/EX pipeline register outputs and produces the EX/MEM register inputs.
//  Single-cycle ALU ops complete combinationally in one cycle.
//  MUL and DIVU run on an iterative unit; freeze stalls the front of the pipe until the result is ready.
//  During a stall, a bubble (all enables 0) is presented to EX/MEM.
// PARAMETERS
//  XLEN      32  datapath width
//  CNT_W     6   iteration counter width, must hold XLEN
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  Dest_in       in   5     destination register from ID/EX
//  Val1_in       in   XLEN  operand 1
//  Val2_in       in   XLEN  operand 2 (reg or sign-extended imm)
//  Reg2_in       in   XLEN  rt value, store data
//  PC_in         in   XLEN  PC+4 of instruction
//  EXE_CMD_in    in   4     operation code
//  MEM_R_EN_in   in   1     load enable
//  MEM_W_EN_in   in   1     store enable
//  WB_EN_in      in   1     writeback enable
//  ALU_result    out  XLEN  result / memory address
//  Br_addr       out  XLEN  PC_in + (Val2_in << 2), always combinational
//  ST_val        out  XLEN  Reg2_in passthrough
//  Dest          out  5     destination passthrough
//  MEM_R_EN      out  1     gated load enable
//  MEM_W_EN      out  1     gated store enable
//  WB_EN         out  1     gated writeback enable
//  freeze        out  1     1 = hold PC, IF/ID and ID/EX registers
// BEHAVIOUR
//  EXE_CMD encoding:
//   0000 ADD, 0001 PASS(Val2), 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR,
//   1000 SLL, 1001 SRA, 1010 SRL (shift Val1 by Val2[4:0]),
//   1100 MUL (low XLEN bits of product), 1101 DIVU (unsigned quotient).
//   Undefined codes give result 0.
//  FSM states: IDLE, RUN, DONE. Reset -> IDLE, count 0, internal regs 0.
//   Reset is the only state that sets freeze=0 regardless of inputs.
//  IDLE, single-cycle op: outputs valid the same cycle; freeze=0; enables = *_in.
//  IDLE, EXE_CMD_in is MUL or DIVU:
//   - capture Val1, Val2 and the command
//   - count <= 0, go to RUN
//   - freeze=1; WB_EN, MEM_R_EN and MEM_W_EN forced to 0
//  RUN: one iteration per cycle; freeze=1; enables forced to 0; ALU_result=0.
//   - After XLEN iterations (count == XLEN-1), go to DONE.
//  DONE: ALU_result = captured result; enables = *_in (ID/EX still holds the op); freeze=0.
//   - Go to IDLE unconditionally; the MUL/DIVU still on the inputs is NOT restarted.
//  Latency: freeze high for XLEN+1 cycles (33); result valid in cycle XLEN+2 (34) after issue.
//  MUL: shift-add, 2*XLEN accumulator; keep the low XLEN bits (sign-agnostic).
//  DIVU: restoring, XLEN+1-bit partial remainder.
//   - Divisor 0 -> quotient all ones (0xFFFFFFFF); no trap.
//  Back-to-back MUL: second one starts in the IDLE cycle that follows DONE.
//  Bubble input (all zeros: ADD, enables 0) passes as harmless ADD 0+0.
//  rst mid-RUN aborts the operation: IDLE, freeze=0 in the next cycle, no result emitted.
//  ADD/SUB wrap modulo 2^XLEN; no overflow flag.
// STRUCTURE
//  mips_defs_pkg: XLEN, EXE_CMD localparams (CMD_ADD..CMD_DIVU), FSM state encoding.
//  Sub-module iter_muldiv_unit holds the FSM, counter, accumulator and divider.
//   - Interface: start, is_div, a, b -> busy, done, result.
//  Top level: combinational ALU, output muxing, enable gating, freeze = start | busy.
// TESTING
//  1. ADD 7+5, SUB 3-5, SRA 0x80000000>>4 -> 12, 0xFFFFFFFE, 0xF8000000 in the same cycle; freeze=0.
//  2. MUL 0x0001_0003 * 0x0002_0004 -> freeze high 33 cycles, enables 0 meanwhile.
//     Then ALU_result=0x000A_000C, WB_EN=1, freeze=0 for 1 cycle.
//  3. DIVU 100/7 -> 14; DIVU 5/0 -> 0xFFFFFFFF; each 34 cycles issue-to-result.
//  4. Two MULs back to back (3*4, then 0xFFFFFFFF*2) -> 12 then 0xFFFFFFFE; no lost or duplicated result.
//  5. rst asserted at RUN count 10 -> next cycle freeze=0, enables 0; a following ADD completes normally.
//  6. Store with Val1=0x100, Val2=8, Reg2=0xABCD -> ALU_result=0x108, ST_val=0xABCD, MEM_W_EN=1.
//     Br_addr = PC_in+32.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared widths, execute command codes and the mul/div sequencer
// state encoding for the execute stage.
package mips_defs_pkg;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 6;
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_PASS = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_DIVU = 4'b1101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/iter_muldiv_unit.sv
// Iterative shift-add multiplier and restoring divider, one bit
// per cycle, XLEN iterations, result held for the single DONE cycle.
module iter_muldiv_unit
  import mips_defs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    // a zero divisor never borrows, so the quotient fills with ones
    trial    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff     = trial - {1'b0, dvsr_q};
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d  = MD_RUN;
          cnt_d    = '0;
          is_div_d = is_div;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, b};
          mplier_d = a;
          quo_d    = a;
          rem_d    = '0;
          dvsr_d   = b;
        end
      end
      MD_RUN: begin
        if (is_div_q) begin
          if (!diff[XLEN]) begin
            rem_d = diff;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = trial;
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN-1)) state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy   = (state_q == MD_RUN);
  assign done   = (state_q == MD_DONE);
  assign result = is_div_q ? quo_q : acc_q[XLEN-1:0];

endmodule

// File: rtl/exe_stage_multicycle.sv
// Execute stage: combinational ALU plus iterative MUL/DIVU that
// freezes the front of the pipe and bubbles EX/MEM until done.
module exe_stage_multicycle
  import mips_defs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      Dest_in,
  input  logic [XLEN-1:0] Val1_in,
  input  logic [XLEN-1:0] Val2_in,
  input  logic [XLEN-1:0] Reg2_in,
  input  logic [XLEN-1:0] PC_in,
  input  logic [3:0]      EXE_CMD_in,
  input  logic            MEM_R_EN_in,
  input  logic            MEM_W_EN_in,
  input  logic            WB_EN_in,
  output logic [XLEN-1:0] ALU_result,
  output logic [XLEN-1:0] Br_addr,
  output logic [XLEN-1:0] ST_val,
  output logic [4:0]      Dest,
  output logic            MEM_R_EN,
  output logic            MEM_W_EN,
  output logic            WB_EN,
  output logic            freeze
);

  logic               is_md;
  logic               md_start;
  logic               md_busy;
  logic               md_done;
  logic [XLEN-1:0]    md_result;
  logic [XLEN-1:0]    alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign is_md = (EXE_CMD_in == CMD_MUL) |
                 (EXE_CMD_in == CMD_DIVU);
  // DONE still sees the op on ID/EX; it must not relaunch it
  assign md_start = is_md & ~md_busy & ~md_done & ~rst;
  assign freeze   = md_start | md_busy;
  assign shamt    = Val2_in[SHAMT_W-1:0];

  iter_muldiv_unit u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (EXE_CMD_in == CMD_DIVU),
    .a      (Val1_in),
    .b      (Val2_in),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    alu_res = '0;
    case (EXE_CMD_in)
      CMD_ADD:  alu_res = Val1_in + Val2_in;
      CMD_PASS: alu_res = Val2_in;
      CMD_SUB:  alu_res = Val1_in - Val2_in;
      CMD_AND:  alu_res = Val1_in & Val2_in;
      CMD_OR:   alu_res = Val1_in | Val2_in;
      CMD_NOR:  alu_res = ~(Val1_in | Val2_in);
      CMD_XOR:  alu_res = Val1_in ^ Val2_in;
      CMD_SLL:  alu_res = Val1_in << shamt;
      CMD_SRA:  alu_res = $unsigned($signed(Val1_in) >>> shamt);
      CMD_SRL:  alu_res = Val1_in >> shamt;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    ALU_result = alu_res;
    if (md_done)     ALU_result = md_result;
    else if (freeze) ALU_result = '0;
  end

  assign MEM_R_EN = MEM_R_EN_in & ~freeze;
  assign MEM_W_EN = MEM_W_EN_in & ~freeze;
  assign WB_EN    = WB_EN_in & ~freeze;
  assign Br_addr  = PC_in + (Val2_in << 2);
  assign ST_val   = Reg2_in;
  assign Dest     = Dest_in;

endmodule

// File: tb/tb_exe_stage_multicycle.sv
// Directed and random checks of the execute stage against a
// plain-arithmetic model of the command set and mul/div latency.
module tb_exe_stage_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Dest_in;
  logic [31:0] Val1_in, Val2_in, Reg2_in, PC_in;
  logic [3:0]  EXE_CMD_in;
  logic        MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [31:0] ALU_result, Br_addr, ST_val;
  logic [4:0]  Dest;
  logic        MEM_R_EN, MEM_W_EN, WB_EN, freeze;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_multicycle dut (
    .clk         (clk),
    .rst         (rst),
    .Dest_in     (Dest_in),
    .Val1_in     (Val1_in),
    .Val2_in     (Val2_in),
    .Reg2_in     (Reg2_in),
    .PC_in       (PC_in),
    .EXE_CMD_in  (EXE_CMD_in),
    .MEM_R_EN_in (MEM_R_EN_in),
    .MEM_W_EN_in (MEM_W_EN_in),
    .WB_EN_in    (WB_EN_in),
    .ALU_result  (ALU_result),
    .Br_addr     (Br_addr),
    .ST_val      (ST_val),
    .Dest        (Dest),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .WB_EN       (WB_EN),
    .freeze      (freeze)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd,
                                          input logic [31:0] v1,
                                          input logic [31:0] v2);
    logic [4:0] sh;
    logic signed [31:0] s1;
    sh = v2[4:0];
    s1 = v1;
    case (cmd)
      4'd0:  return v1 + v2;
      4'd1:  return v2;
      4'd2:  return v1 - v2;
      4'd4:  return v1 & v2;
      4'd5:  return v1 | v2;
      4'd6:  return ~(v1 | v2);
      4'd7:  return v1 ^ v2;
      4'd8:  return v1 << sh;
      4'd9:  return 32'(s1 >>> sh);
      4'd10: return v1 >> sh;
      4'd12: return v1 * v2;
      4'd13: return (v2 == 0) ? 32'hFFFF_FFFF : v1 / v2;
      default: return 32'h0;
    endcase
  endfunction

  task automatic bubble();
    Dest_in = '0; Val1_in = '0; Val2_in = '0; Reg2_in = '0;
    PC_in = '0; EXE_CMD_in = '0;
    MEM_R_EN_in = 0; MEM_W_EN_in = 0; WB_EN_in = 0;
  endtask

  // Called just after a rising edge; returns just after the edge
  // that follows the cycle in which the result is presented.
  task automatic run_op(input string tag, input logic [3:0] cmd,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] r2, input logic [31:0] pc,
                        input logic [4:0] d, input logic r,
                        input logic w, input logic wb);
    int n;
    int en_bad;
    bit md;
    Dest_in = d; Val1_in = v1; Val2_in = v2; Reg2_in = r2;
    PC_in = pc; EXE_CMD_in = cmd;
    MEM_R_EN_in = r; MEM_W_EN_in = w; WB_EN_in = wb;
    md = (cmd == 4'd12) || (cmd == 4'd13);
    n = 0;
    en_bad = 0;
    @(negedge clk);
    while (freeze && n < 100) begin
      if (MEM_R_EN || MEM_W_EN || WB_EN) en_bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_frz_cycles"}, n, md ? 33 : 0);
    if (md) chk({tag, "_en_during_frz"}, en_bad, 0);
    chk({tag, "_res"}, ALU_result, ref_alu(cmd, v1, v2));
    chk({tag, "_en"}, {29'd0, MEM_R_EN, MEM_W_EN, WB_EN},
        {29'd0, r, w, wb});
    chk({tag, "_dest"}, {27'd0, Dest}, {27'd0, d});
    chk({tag, "_st"}, ST_val, r2);
    chk({tag, "_br"}, Br_addr, pc + v2 * 4);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1;
    bubble();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_freeze", {31'd0, freeze}, 0);
    chk("rst_res", ALU_result, 0);
    chk("rst_wb", {31'd0, WB_EN}, 0);
    @(posedge clk); #1;

    run_op("add", 4'd0, 7, 5, 0, 32'h40, 5'd1, 0, 0, 1);
    run_op("sub", 4'd2, 3, 5, 0, 32'h44, 5'd2, 0, 0, 1);
    run_op("sra", 4'd9, 32'h8000_0000, 4, 0, 32'h48, 5'd3, 0, 0, 1);
    run_op("mul", 4'd12, 32'h0001_0003, 32'h0002_0004, 0, 32'h4C,
           5'd4, 0, 0, 1);
    run_op("divu", 4'd13, 100, 7, 0, 32'h50, 5'd5, 0, 0, 1);
    run_op("div0", 4'd13, 5, 0, 0, 32'h54, 5'd6, 0, 0, 1);
    run_op("mul_b2b1", 4'd12, 3, 4, 0, 32'h58, 5'd7, 0, 0, 1);
    run_op("mul_b2b2", 4'd12, 32'hFFFF_FFFF, 2, 0, 32'h5C,
           5'd8, 0, 0, 1);
    run_op("store", 4'd0, 32'h100, 8, 32'hABCD, 32'h400,
           5'd0, 0, 1, 0);
    run_op("undef", 4'd15, 32'h1234, 32'h5678, 0, 0, 5'd9, 0, 0, 1);

    // abort a MUL at iteration 10
    Val1_in = 9; Val2_in = 9; EXE_CMD_in = 4'd12; WB_EN_in = 1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    bubble();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_freeze", {31'd0, freeze}, 0);
    chk("abort_en", {29'd0, MEM_R_EN, MEM_W_EN, WB_EN}, 0);
    chk("abort_res", ALU_result, 0);
    @(posedge clk); #1;
    run_op("post_abort_add", 4'd0, 20, 22, 0, 32'h80, 5'd10, 1, 0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] c;
      logic [31:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                      : $urandom;
      run_op("rnd", c, a, b, $urandom, $urandom, 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
